// File: rtl/uart_pwm_ctrl_if.sv
// Byte-stream and drive-side signals of the UART-programmed PWM controller.
// The master side feeds received bytes in; the slave side produces the PWM lines and status pulses.
interface uart_pwm_ctrl_if #(
    parameter int NCH = 5
);
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic [NCH-1:0] oPWM;
    logic           cmd_ok;
    logic           cmd_err;
    logic           busy;

    modport master (output rx_valid, rx_data, input oPWM, cmd_ok, cmd_err, busy);
    modport slave  (input rx_valid, rx_data, output oPWM, cmd_ok, cmd_err, busy);
endinterface

// File: rtl/uart_pwm_ctrl.sv
// Multi-channel PWM whose duties are written by 4-byte UART frames (A5, CH, DUTY, SUM).
// Shadow duties become active only at the counter wrap, so a period is never torn.
module uart_pwm_ch #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic          i_wrap,
    input  logic [CW-1:0] i_duty,
    input  logic [CW-1:0] i_cnt_nxt,
    output logic          o_pwm
);
    logic [CW-1:0] r_shadow;
    logic [CW-1:0] r_active;
    logic [CW-1:0] w_act_nxt;
    logic          r_pwm;

    // A write landing on the wrap edge goes straight to active.
    always_comb w_act_nxt = i_wrap ? (i_wr ? i_duty : r_shadow) : r_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_wr) r_shadow <= i_duty;
            r_active <= w_act_nxt;
            r_pwm    <= (i_cnt_nxt < w_act_nxt);
        end
    end

    assign o_pwm = r_pwm;
endmodule

module uart_pwm_ctrl #(
    parameter int NCH     = 5,
    parameter int CW      = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic           clk,
    input  logic           reset,
    uart_pwm_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GET_CH   = 2'd1;
    localparam logic [1:0] S_GET_DUTY = 2'd2;
    localparam logic [1:0] S_GET_SUM  = 2'd3;
    localparam logic [7:0] HDR        = 8'hA5;

    logic [1:0]     r_state, w_state_nxt;
    logic [7:0]     r_ch, r_duty;
    logic [TW-1:0]  r_tcnt;
    logic           r_ok, r_err, r_busy;
    logic [CW-1:0]  r_cnt, w_cnt_nxt, w_duty;
    logic           w_wrap, w_last, w_good, w_tmo;
    logic [NCH-1:0] w_pwm;

    assign w_last = bus.rx_valid && (r_state == S_GET_SUM);
    assign w_good = (8'(r_ch + r_duty) == bus.rx_data) && (r_ch < 8'(NCH));
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_tmo  = !bus.rx_valid && (r_state != S_IDLE) && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_duty = CW'(r_duty);

    assign w_wrap    = (r_cnt == {{(CW-1){1'b1}}, 1'b0});
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.rx_valid) begin
            case (r_state)
                S_IDLE:     if (bus.rx_data == HDR) w_state_nxt = S_GET_CH;
                S_GET_CH:   w_state_nxt = S_GET_DUTY;
                S_GET_DUTY: w_state_nxt = S_GET_SUM;
                default:    w_state_nxt = S_IDLE;
            endcase
        end else if (w_tmo) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ch    <= '0;
            r_duty  <= '0;
            r_tcnt  <= '0;
            r_ok    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (bus.rx_valid && r_state == S_GET_CH)   r_ch   <= bus.rx_data;
            if (bus.rx_valid && r_state == S_GET_DUTY) r_duty <= bus.rx_data;
            r_ok  <= w_last && w_good;
            r_err <= (w_last && !w_good) || w_tmo;
            if (bus.rx_valid || r_state == S_IDLE || w_tmo) r_tcnt <= '0;
            else                                           r_tcnt <= r_tcnt + 1'b1;
            r_cnt <= w_cnt_nxt;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        uart_pwm_ch #(.CW(CW)) u_ch (
            .clk       (clk),
            .rst       (reset),
            .i_wr      (w_last && w_good && (r_ch == 8'(g))),
            .i_wrap    (w_wrap),
            .i_duty    (w_duty),
            .i_cnt_nxt (w_cnt_nxt),
            .o_pwm     (w_pwm[g])
        );
    end

    assign bus.oPWM    = w_pwm;
    assign bus.cmd_ok  = r_ok;
    assign bus.cmd_err = r_err;
    assign bus.busy    = r_busy;
endmodule
